// File: rtl/sync_byte_fifo_if.sv
// sync_byte_fifo_if: write/read handshake and status bundle
// for the single-clock byte FIFO.
interface sync_byte_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             full;
    logic             almost_full;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output wr_en, din, rd_en, clr_err,
        input  full, almost_full, dout, empty,
        input  almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, clr_err,
        output full, almost_full, dout, empty,
        output almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: single-clock byte FIFO with registered read
// data, occupancy/threshold status and sticky error flags.
module sync_byte_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input logic             clk,
    input logic             rst,
    sync_byte_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] dout_q;
    logic             ovf_q;
    logic             unf_q;

    logic full_w;
    logic empty_w;
    logic wr_ok;
    logic rd_ok;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);
    assign wr_ok   = bus.wr_en && !full_w;
    assign rd_ok   = bus.rd_en && !empty_w;

    // Storage write; contents are never reset, only gated in reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout_q <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags; a new error beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q && !bus.clr_err) || (bus.wr_en && full_w);
            unf_q <= (unf_q && !bus.clr_err) || (bus.rd_en && empty_w);
        end
    end

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.dout         = dout_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_byte_fifo.sv
// tb_sync_byte_fifo: directed scenarios for the byte FIFO
// with hand-computed expectations.
module tb_sync_byte_fifo;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    sync_byte_fifo_if #(.WIDTH(8), .DEPTH(32)) bus ();

    sync_byte_fifo #(
        .WIDTH(8),
        .DEPTH(32),
        .AF_LEVEL(28),
        .AE_LEVEL(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then stable for checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        bus.din     = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if (bus.empty !== 1'b1)
            $display("FAIL rst_empty got %b want 1", bus.empty);
        else pass_cnt++;
        total_cnt++;
        if (bus.full !== 1'b0)
            $display("FAIL rst_full got %b want 0", bus.full);
        else pass_cnt++;
        total_cnt++;
        if (bus.count !== 6'd0)
            $display("FAIL rst_count got %0d want 0", bus.count);
        else pass_cnt++;
        total_cnt++;
        if (bus.dout !== 8'h00)
            $display("FAIL rst_dout got %h want 00", bus.dout);
        else pass_cnt++;
        total_cnt++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0)
            $display("FAIL rst_flags got %b%b want 00",
                     bus.overflow, bus.underflow);
        else pass_cnt++;
        total_cnt++;
        if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0)
            $display("FAIL rst_almost got ae=%b af=%b want ae=1 af=0",
                     bus.almost_empty, bus.almost_full);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [7:0] v [3];
        v[0] = 8'h31;
        v[1] = 8'h41;
        v[2] = 8'h5A;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.din = v[i];
            tick();
            total_cnt++;
            if (bus.count !== 6'(i + 1) || bus.empty !== 1'b0)
                $display("FAIL basic_wr%0d count %0d empty %b want %0d 0",
                         i, bus.count, bus.empty, i + 1);
            else pass_cnt++;
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (bus.dout !== v[i])
                $display("FAIL basic_rd%0d got %h want %h",
                         i, bus.dout, v[i]);
            else pass_cnt++;
        end
        bus.rd_en = 1'b0;
        total_cnt++;
        if (bus.count !== 6'd0 || bus.empty !== 1'b1)
            $display("FAIL basic_end count %0d empty %b want 0 1",
                     bus.count, bus.empty);
        else pass_cnt++;
    endtask

    task automatic test_fill_overflow();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.din = 8'(i);
            tick();
            total_cnt++;
            if (bus.count !== 6'(i + 1) ||
                bus.almost_full !== ((i + 1) >= 28) ||
                bus.full !== ((i + 1) == 32) ||
                bus.almost_empty !== ((i + 1) <= 4))
                $display("FAIL fill%0d count %0d af %b f %b ae %b",
                         i, bus.count, bus.almost_full,
                         bus.full, bus.almost_empty);
            else pass_cnt++;
        end
        bus.din = 8'hFF;
        tick();
        bus.wr_en = 1'b0;
        total_cnt++;
        if (bus.overflow !== 1'b1 || bus.count !== 6'd32)
            $display("FAIL ovf got ovf %b count %0d want 1 32",
                     bus.overflow, bus.count);
        else pass_cnt++;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            total_cnt++;
            if (bus.dout !== 8'(i))
                $display("FAIL drain%0d got %h want %h",
                         i, bus.dout, 8'(i));
            else pass_cnt++;
        end
        bus.rd_en = 1'b0;
        total_cnt++;
        if (bus.empty !== 1'b1 || bus.underflow !== 1'b0)
            $display("FAIL drain_end empty %b unf %b want 1 0",
                     bus.empty, bus.underflow);
        else pass_cnt++;
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        total_cnt++;
        if (bus.overflow !== 1'b0)
            $display("FAIL ovf_clr got %b want 0", bus.overflow);
        else pass_cnt++;
    endtask

    task automatic test_full_rw();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.din = 8'(8'h60 + i);
            tick();
        end
        bus.din   = 8'hAA;
        bus.rd_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        total_cnt++;
        if (bus.count !== 6'd31 || bus.full !== 1'b0)
            $display("FAIL full_rw count %0d full %b want 31 0",
                     bus.count, bus.full);
        else pass_cnt++;
        total_cnt++;
        if (bus.dout !== 8'h60)
            $display("FAIL full_rw_dout got %h want 60", bus.dout);
        else pass_cnt++;
        total_cnt++;
        if (bus.overflow !== 1'b1)
            $display("FAIL full_rw_ovf got %b want 1", bus.overflow);
        else pass_cnt++;
        for (int i = 1; i < 32; i++) begin
            tick();
            total_cnt++;
            if (bus.dout !== 8'(8'h60 + i))
                $display("FAIL full_rw_drain%0d got %h want %h",
                         i, bus.dout, 8'(8'h60 + i));
            else pass_cnt++;
        end
        bus.rd_en = 1'b0;
        total_cnt++;
        if (bus.empty !== 1'b1 || bus.count !== 6'd0)
            $display("FAIL full_rw_end empty %b count %0d want 1 0",
                     bus.empty, bus.count);
        else pass_cnt++;
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
    endtask

    task automatic test_empty_rw();
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.din   = 8'h55;
        tick();
        bus.wr_en = 1'b0;
        total_cnt++;
        if (bus.underflow !== 1'b1 || bus.count !== 6'd1)
            $display("FAIL empty_rw unf %b count %0d want 1 1",
                     bus.underflow, bus.count);
        else pass_cnt++;
        total_cnt++;
        if (bus.dout !== 8'h7F)
            $display("FAIL empty_rw_dout got %h want 7f", bus.dout);
        else pass_cnt++;
        tick();
        bus.rd_en = 1'b0;
        total_cnt++;
        if (bus.dout !== 8'h55 || bus.count !== 6'd0)
            $display("FAIL empty_rw_rd dout %h count %0d want 55 0",
                     bus.dout, bus.count);
        else pass_cnt++;
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        total_cnt++;
        if (bus.underflow !== 1'b0)
            $display("FAIL unf_clr got %b want 0", bus.underflow);
        else pass_cnt++;
    endtask

    task automatic test_wrap_and_reset();
        logic [7:0] d;
        for (int i = 0; i < 100; i++) begin
            d = 8'($urandom_range(0, 255));
            bus.din   = d;
            bus.wr_en = 1'b1;
            tick();
            bus.wr_en = 1'b0;
            bus.rd_en = 1'b1;
            tick();
            bus.rd_en = 1'b0;
            total_cnt++;
            if (bus.dout !== d || bus.count !== 6'd0)
                $display("FAIL wrap%0d dout %h count %0d want %h 0",
                         i, bus.dout, bus.count, d);
            else pass_cnt++;
        end
        bus.wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.din = 8'(8'hC0 + i);
            tick();
        end
        total_cnt++;
        if (bus.count !== 6'd5)
            $display("FAIL pre_rst count %0d want 5", bus.count);
        else pass_cnt++;
        rst = 1'b1;
        bus.rd_en = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        total_cnt++;
        if (bus.count !== 6'd0 || bus.empty !== 1'b1)
            $display("FAIL mid_rst count %0d empty %b want 0 1",
                     bus.count, bus.empty);
        else pass_cnt++;
        total_cnt++;
        if (bus.dout !== 8'h00 || bus.underflow !== 1'b0)
            $display("FAIL mid_rst_dout %h unf %b want 00 0",
                     bus.dout, bus.underflow);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_rw();
        test_empty_rw();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
